// File: rtl/cache_pkg.sv
// Shared types and helpers for the set-associative cache slice.
// Default geometry plus the byte-lane merge used on CPU writes.
package cache_pkg;

   localparam int CACHE_T   = 20;
   localparam int CACHE_B   = 4;
   localparam int CACHE_W   = 4;
   localparam int LINE_SIZE = 2 ** (CACHE_B - 2);

   typedef logic [$clog2(CACHE_W)-1:0] way_idx_t;
   typedef logic [$clog2(CACHE_W)-1:0] age_t;

   function automatic int line_words(input int offset_width);
      return 2 ** (offset_width - 2);
   endfunction

   // Lane k of the result comes from data when be[k] is set, else from old.
   function automatic logic [31:0] be_merge(
      input logic [31:0] old,
      input logic [31:0] data,
      input logic [3:0]  be
   );
      logic [31:0] res;
      res = old;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) res[8*k +: 8] = data[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/cache_way.sv
// One cache line: valid, dirty, tag and word storage with
// byte-enabled writes, full-word fills, install and tag compare.
module cache_way
   import cache_pkg::*;
#(
   parameter  int TAG_WIDTH    = CACHE_T,
   parameter  int OFFSET_WIDTH = CACHE_B,
   localparam int WOFF         = OFFSET_WIDTH - 2,
   localparam int WORDS        = line_words(OFFSET_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [TAG_WIDTH-1:0] lookup_tag,
   input  logic [WOFF-1:0]      offset,
   input  logic                 write_en,
   input  logic [3:0]           byte_en,
   input  logic [31:0]          write_data,
   input  logic                 fill_en,
   input  logic                 install,
   output logic                 valid,
   output logic                 dirty,
   output logic [TAG_WIDTH-1:0] line_tag,
   output logic                 hit,
   output logic [31:0]          word
);

   logic [31:0] data [WORDS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WORDS; i++) data[i] <= '0;
      end else if (fill_en) begin
         data[offset] <= write_data;
      end else if (write_en) begin
         data[offset] <= be_merge(data[offset], write_data, byte_en);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid    <= 1'b0;
         dirty    <= 1'b0;
         line_tag <= '0;
      end else if (install) begin
         valid    <= 1'b1;
         dirty    <= 1'b0;
         line_tag <= lookup_tag;
      end else if (write_en) begin
         dirty    <= 1'b1;
      end
   end

   assign hit  = valid && (line_tag == lookup_tag);
   assign word = data[offset];

endmodule

// File: rtl/cache_set.sv
// One set of an N-way cache: parallel lookup, true-LRU ages,
// victim selection and fill/access priority.
module cache_set
   import cache_pkg::*;
#(
   parameter  int TAG_WIDTH    = CACHE_T,
   parameter  int OFFSET_WIDTH = CACHE_B,
   parameter  int NUM_WAYS     = CACHE_W,
   localparam int LINE_SIZE    = line_words(OFFSET_WIDTH),
   localparam int WW           = $clog2(NUM_WAYS),
   localparam int WOFF         = OFFSET_WIDTH - 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [TAG_WIDTH-1:0] tag_i,
   input  logic [WOFF-1:0]      offset_i,
   input  logic                 access_en_i,
   input  logic                 write_en_i,
   input  logic [3:0]           byte_en_i,
   input  logic [31:0]          write_data_i,
   input  logic                 fill_en_i,
   input  logic                 fill_done_i,
   output logic                 hit_o,
   output logic [WW-1:0]        hit_way_o,
   output logic [31:0]          read_data_o,
   output logic [WW-1:0]        victim_way_o,
   output logic                 victim_valid_o,
   output logic                 victim_dirty_o,
   output logic [TAG_WIDTH-1:0] victim_tag_o,
   output logic [31:0]          victim_data_o
);

   logic [NUM_WAYS-1:0]  way_valid;
   logic [NUM_WAYS-1:0]  way_dirty;
   logic [NUM_WAYS-1:0]  way_hit;
   logic [NUM_WAYS-1:0]  way_write;
   logic [NUM_WAYS-1:0]  way_fill;
   logic [NUM_WAYS-1:0]  way_install;
   logic [TAG_WIDTH-1:0] way_tag  [NUM_WAYS];
   logic [31:0]          way_word [NUM_WAYS];
   logic [WW-1:0]        age      [NUM_WAYS];

   logic                 fill_path;
   logic                 cpu_hit;
   logic                 touch_en;
   logic [WW-1:0]        touch_way;
   logic [WW-1:0]        hw;
   logic [WW-1:0]        vic;
   logic                 found;

   for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
      cache_way #(
         .TAG_WIDTH    (TAG_WIDTH),
         .OFFSET_WIDTH (OFFSET_WIDTH)
      ) u_way (
         .clk        (clk_i),
         .rst        (rst_i),
         .lookup_tag (tag_i),
         .offset     (offset_i),
         .write_en   (way_write[w]),
         .byte_en    (byte_en_i),
         .write_data (write_data_i),
         .fill_en    (way_fill[w]),
         .install    (way_install[w]),
         .valid      (way_valid[w]),
         .dirty      (way_dirty[w]),
         .line_tag   (way_tag[w]),
         .hit        (way_hit[w]),
         .word       (way_word[w])
      );
   end

   // Scan downward so the lowest-index hit wins.
   always_comb begin
      hw = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (way_hit[w]) hw = WW'(w);
      end
   end

   assign hit_o       = |way_hit;
   assign hit_way_o   = hw;
   assign read_data_o = hit_o ? way_word[hw] : 32'h0;

   always_comb begin
      vic   = '0;
      found = 1'b0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!found && !way_valid[w]) begin
            vic   = WW'(w);
            found = 1'b1;
         end
      end
      if (!found) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (age[w] == WW'(NUM_WAYS - 1)) vic = WW'(w);
         end
      end
   end

   assign victim_way_o   = vic;
   assign victim_valid_o = way_valid[vic];
   assign victim_dirty_o = way_dirty[vic];
   assign victim_tag_o   = way_tag[vic];
   assign victim_data_o  = way_word[vic];

   // A fill beat or install blocks the CPU access entirely.
   assign fill_path = fill_en_i | fill_done_i;
   assign cpu_hit   = !fill_path && access_en_i && hit_o;
   assign touch_en  = fill_done_i | cpu_hit;
   assign touch_way = fill_done_i ? vic : hw;

   always_comb begin
      way_write   = '0;
      way_fill    = '0;
      way_install = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         way_write[w]   = cpu_hit && write_en_i && (hw == WW'(w));
         way_fill[w]    = fill_en_i && (vic == WW'(w));
         way_install[w] = fill_done_i && (vic == WW'(w));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int w = 0; w < NUM_WAYS; w++) age[w] <= WW'(w);
      end else if (touch_en) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (WW'(w) == touch_way)
               age[w] <= '0;
            else if (age[w] < age[touch_way])
               age[w] <= age[w] + WW'(1);
         end
      end
   end

endmodule

// File: tb/tb_cache_set.sv
// Directed vector table plus an async-reset-mid-fill sequence
// for the 4-way cache set.
module tb_cache_set;

   localparam logic N = 1'b0;
   localparam logic Y = 1'b1;

   typedef struct {
      logic        acc;
      logic        wr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        fill;
      logic        done;
      logic [19:0] tag;
      logic [1:0]  off;
      logic        hit;
      logic [1:0]  hw;
      logic [31:0] rd;
      logic [1:0]  vw;
      logic        vv;
      logic        vd;
      logic [19:0] vt;
      logic [31:0] vdat;
   } vec_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [19:0] tag_i;
   logic [1:0]  offset_i;
   logic        access_en_i;
   logic        write_en_i;
   logic [3:0]  byte_en_i;
   logic [31:0] write_data_i;
   logic        fill_en_i;
   logic        fill_done_i;
   logic        hit_o;
   logic [1:0]  hit_way_o;
   logic [31:0] read_data_o;
   logic [1:0]  victim_way_o;
   logic        victim_valid_o;
   logic        victim_dirty_o;
   logic [19:0] victim_tag_o;
   logic [31:0] victim_data_o;

   int vectors     = 0;
   int miscompares = 0;
   int cur         = 0;

   vec_t tbl [22];

   cache_set #(
      .TAG_WIDTH    (20),
      .OFFSET_WIDTH (4),
      .NUM_WAYS     (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .tag_i          (tag_i),
      .offset_i       (offset_i),
      .access_en_i    (access_en_i),
      .write_en_i     (write_en_i),
      .byte_en_i      (byte_en_i),
      .write_data_i   (write_data_i),
      .fill_en_i      (fill_en_i),
      .fill_done_i    (fill_done_i),
      .hit_o          (hit_o),
      .hit_way_o      (hit_way_o),
      .read_data_o    (read_data_o),
      .victim_way_o   (victim_way_o),
      .victim_valid_o (victim_valid_o),
      .victim_dirty_o (victim_dirty_o),
      .victim_tag_o   (victim_tag_o),
      .victim_data_o  (victim_data_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s step %0d: got %h want %h", name, cur, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      access_en_i  = v.acc;
      write_en_i   = v.wr;
      byte_en_i    = v.be;
      write_data_i = v.wd;
      fill_en_i    = v.fill;
      fill_done_i  = v.done;
      tag_i        = v.tag;
      offset_i     = v.off;
   endtask

   task automatic check_vec(input vec_t v);
      vectors++;
      chk("hit",    {31'h0, hit_o},          {31'h0, v.hit});
      chk("hitway", {30'h0, hit_way_o},      {30'h0, v.hw});
      chk("rdata",  read_data_o,             v.rd);
      chk("vway",   {30'h0, victim_way_o},   {30'h0, v.vw});
      chk("vvalid", {31'h0, victim_valid_o}, {31'h0, v.vv});
      chk("vdirty", {31'h0, victim_dirty_o}, {31'h0, v.vd});
      chk("vtag",   {12'h0, victim_tag_o},   {12'h0, v.vt});
      chk("vdata",  victim_data_o,           v.vdat);
   endtask

   initial begin
      //          acc wr be    wd            fill done tag    off  hit hw rd            vw vv vd vt     vdat
      tbl[0]  = '{N, N, 4'h0, 32'h0,        N, N, 20'h1, 2'd0, N, 2'd0, 32'h0,        2'd0, N, N, 20'h0, 32'h0};
      tbl[1]  = '{N, N, 4'h0, 32'hA0,       Y, N, 20'h1, 2'd0, N, 2'd0, 32'h0,        2'd0, N, N, 20'h0, 32'h0};
      tbl[2]  = '{N, N, 4'h0, 32'hA1,       Y, N, 20'h1, 2'd1, N, 2'd0, 32'h0,        2'd0, N, N, 20'h0, 32'h0};
      tbl[3]  = '{N, N, 4'h0, 32'hA2,       Y, N, 20'h1, 2'd2, N, 2'd0, 32'h0,        2'd0, N, N, 20'h0, 32'h0};
      tbl[4]  = '{N, N, 4'h0, 32'hA3,       Y, Y, 20'h1, 2'd3, N, 2'd0, 32'h0,        2'd0, N, N, 20'h0, 32'h0};
      tbl[5]  = '{Y, N, 4'h0, 32'h0,        N, N, 20'h1, 2'd2, Y, 2'd0, 32'hA2,       2'd1, N, N, 20'h0, 32'h0};
      tbl[6]  = '{Y, Y, 4'hF, 32'hAABBCCDD, N, N, 20'h1, 2'd2, Y, 2'd0, 32'hA2,       2'd1, N, N, 20'h0, 32'h0};
      tbl[7]  = '{Y, Y, 4'h5, 32'h11223344, N, N, 20'h1, 2'd2, Y, 2'd0, 32'hAABBCCDD, 2'd1, N, N, 20'h0, 32'h0};
      tbl[8]  = '{N, N, 4'h0, 32'h0,        N, N, 20'h1, 2'd2, Y, 2'd0, 32'hAA22CC44, 2'd1, N, N, 20'h0, 32'h0};
      tbl[9]  = '{N, N, 4'h0, 32'hB0,       Y, Y, 20'h2, 2'd0, N, 2'd0, 32'h0,        2'd1, N, N, 20'h0, 32'h0};
      tbl[10] = '{N, N, 4'h0, 32'hC0,       Y, Y, 20'h3, 2'd0, N, 2'd0, 32'h0,        2'd2, N, N, 20'h0, 32'h0};
      tbl[11] = '{N, N, 4'h0, 32'hD0,       Y, Y, 20'h4, 2'd0, N, 2'd0, 32'h0,        2'd3, N, N, 20'h0, 32'h0};
      tbl[12] = '{Y, N, 4'h0, 32'h0,        N, N, 20'h1, 2'd2, Y, 2'd0, 32'hAA22CC44, 2'd0, Y, Y, 20'h1, 32'hAA22CC44};
      tbl[13] = '{Y, N, 4'h0, 32'h0,        N, N, 20'h2, 2'd0, Y, 2'd1, 32'hB0,       2'd1, Y, N, 20'h2, 32'hB0};
      tbl[14] = '{N, N, 4'h0, 32'h0,        N, N, 20'h3, 2'd0, Y, 2'd2, 32'hC0,       2'd2, Y, N, 20'h3, 32'hC0};
      tbl[15] = '{Y, Y, 4'hF, 32'h55555555, Y, N, 20'h4, 2'd1, Y, 2'd3, 32'h0,        2'd2, Y, N, 20'h3, 32'h0};
      tbl[16] = '{N, N, 4'h0, 32'h0,        N, N, 20'h4, 2'd1, Y, 2'd3, 32'h0,        2'd2, Y, N, 20'h3, 32'h55555555};
      tbl[17] = '{N, N, 4'h0, 32'h0,        N, N, 20'h3, 2'd1, Y, 2'd2, 32'h55555555, 2'd2, Y, N, 20'h3, 32'h55555555};
      tbl[18] = '{Y, Y, 4'hF, 32'hFFFFFFFF, N, N, 20'h7, 2'd0, N, 2'd0, 32'h0,        2'd2, Y, N, 20'h3, 32'hC0};
      tbl[19] = '{N, N, 4'h0, 32'h0,        N, N, 20'h3, 2'd0, Y, 2'd2, 32'hC0,       2'd2, Y, N, 20'h3, 32'hC0};
      tbl[20] = '{Y, Y, 4'h0, 32'h12345678, N, N, 20'h3, 2'd0, Y, 2'd2, 32'hC0,       2'd2, Y, N, 20'h3, 32'hC0};
      tbl[21] = '{N, N, 4'h0, 32'h0,        N, N, 20'h3, 2'd0, Y, 2'd2, 32'hC0,       2'd3, Y, N, 20'h4, 32'hD0};

      rst_i = 1'b1;
      drive(tbl[0]);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < 22; i++) begin
         cur = i;
         @(negedge clk_i);
         drive(tbl[i]);
         #1;
         check_vec(tbl[i]);
      end

      // Two fill beats to the victim, then reset between edges.
      cur = 100;
      @(negedge clk_i);
      drive('{N, N, 4'h0, 32'hE0, Y, N, 20'h3, 2'd0,
              N, 2'd0, 32'h0, 2'd0, N, N, 20'h0, 32'h0});
      @(negedge clk_i);
      write_data_i = 32'hE1;
      offset_i     = 2'd1;
      @(posedge clk_i);
      #2;
      vectors++;
      chk("pre_rst_hit",   {31'h0, hit_o},          32'h1);
      chk("pre_rst_vval",  {31'h0, victim_valid_o}, 32'h1);
      chk("pre_rst_vway",  {30'h0, victim_way_o},   32'h3);
      chk("pre_rst_vdata", victim_data_o,           32'hE1);
      cur = 101;
      rst_i = 1'b1;
      #1;
      vectors++;
      chk("rst_hit",   {31'h0, hit_o},          32'h0);
      chk("rst_vval",  {31'h0, victim_valid_o}, 32'h0);
      chk("rst_vway",  {30'h0, victim_way_o},   32'h0);
      chk("rst_rdata", read_data_o,             32'h0);
      chk("rst_vdata", victim_data_o,           32'h0);
      @(negedge clk_i);
      fill_en_i = 1'b0;
      rst_i     = 1'b0;
      @(negedge clk_i);
      cur = 102;
      tag_i    = 20'h1;
      offset_i = 2'd2;
      #1;
      vectors++;
      chk("post_hit1",  {31'h0, hit_o},          32'h0);
      chk("post_rd1",   read_data_o,             32'h0);
      chk("post_vdat1", victim_data_o,           32'h0);
      chk("post_vval1", {31'h0, victim_valid_o}, 32'h0);
      @(negedge clk_i);
      cur = 103;
      tag_i = 20'h3;
      #1;
      vectors++;
      chk("post_hit3", {31'h0, hit_o},        32'h0);
      chk("post_vway", {30'h0, victim_way_o}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
